section_diff_restore: RTL
=========================

// Module: section_diff_restore
// PURPOSE
//  Receive-side counterpart of the section difference buffer: rebuilds absolute
//  audio sample values from a section-coded difference stream.
//  Each section holds sample_count words:
//  - word 0 is an absolute sample;
//  - words 1..sample_count-1 are two's-complement deltas from the previous sample.
//  Sits between the diff stream and the level-meter consumer.
//  Uses valid/ready on both sides and has one output register stage.
// PARAMETERS
//  width         16  bit width of input words and restored samples
//  sample_count  3   words per section (>=1); word 0 of each section is absolute
// PORTS
//  clk      in   1      single clock, all logic on rising edge
//  reset    in   1      synchronous, active-low reset (sampled on clk rising edge)
//  i_valid  in   1      input word valid
//  i_ready  out  1      block can accept input word this cycle
//  i_value  in   width  absolute sample (section word 0) or delta (other words)
//  o_valid  out  1      restored sample valid
//  o_ready  in   1      consumer accepts o_value this cycle
//  o_value  out  width  restored absolute sample
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): o_valid=0, o_value=0, idx=0, acc=0.
//    Any partial section is discarded; the next accepted word is treated as absolute.
//  - i_ready = !o_valid || o_ready (combinational).
//    Accept = i_valid && i_ready. i_ready is never asserted during reset.
//  - On accept:
//    - idx==0: acc <= i_value.
//    - idx!=0: acc <= acc + i_value, mod 2^width; wraps silently, carry dropped.
//    - o_value <= new acc; o_valid <= 1.
//    - idx <= (idx==sample_count-1) ? 0 : idx+1.
//  - Latency: one cycle from input accept to o_valid.
//    Full throughput of 1 word/clk when o_ready is held at 1.
//  - Output consumed (o_valid && o_ready) with no accept in the same cycle: o_valid <= 0.
//  - Consume and accept in the same cycle: o_valid stays 1 and o_value takes the new sample.
//  - o_valid && !o_ready: o_value and o_valid are held stable; i_ready=0; acc and idx frozen.
//  - sample_count==1: every word is absolute (pass-through with one-cycle latency).
//  - idx width = max(1, $clog2(sample_count)).
//    Out-of-range parameters (sample_count<1) are an elaboration error.
//  - i_value is ignored when i_valid==0 or i_ready==0.
//    No state changes without an accept or a consume.
// CONFIGURATION
//  SECTION_DIFF_RESTORE_LAST_EN
//  - Defined: adds output port o_last (1 bit), registered alongside o_value.
//    - o_last is 1 on the restored sample produced from section word sample_count-1, else 0.
//    - o_last resets to 0 and is held stable with o_value under backpressure.
//  - Undefined: no o_last port and no related logic.
//    All other behaviour is identical.
// TESTING  (width=16, sample_count=3, o_ready=1 unless stated)
//  1. After reset, feed 1111,0000,1111
//     -> o_value 1111,1111,2222, each 1 clk after its accept.
//  2. Feed section 9999,7777,0000
//     -> 9999,1110,1110 (16-bit wrap, carry dropped).
//  3. Feed 2222 as a fresh section after a completed section
//     -> o_value 2222 (treated as absolute, acc not summed).
//  4. Hold o_ready=0 with an output pending and i_valid=1 for 4 clks
//     -> i_ready=0, o_value/o_valid stable.
//     Then release o_ready -> the next word is accepted on the same edge.
//  5. Accept 4444,1111, assert reset low 1 clk, then feed 5555
//     -> o_valid=0 during reset, next output 5555 (idx restarted).
//  6. SECTION_DIFF_RESTORE_LAST_EN defined, feed 6 words back-to-back
//     -> o_last = 0,0,1,0,0,1.
//     Undefined: bench compiles without o_last and outputs match scenarios 1-5.

Source files
------------

// File: rtl/section_diff_restore.sv
// Rebuilds absolute samples from a section-coded difference stream (word 0 absolute, rest deltas).
// Optional o_last output is enabled by defining SECTION_DIFF_RESTORE_LAST_EN.
module section_diff_restore #(
    parameter int width        = 16,
    parameter int sample_count = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [width-1:0] i_value,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [width-1:0] o_value
`ifdef SECTION_DIFF_RESTORE_LAST_EN
    ,
    output logic             o_last
`endif
);

    localparam int IDX_W = (sample_count > 1) ? $clog2(sample_count) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(sample_count - 1);

    if (sample_count < 1) begin : g_bad_sample_count
        $error("section_diff_restore: sample_count must be >= 1");
    end

    logic [IDX_W-1:0] idx;
    logic [width-1:0] acc;
    logic [width-1:0] acc_next;
    logic             accept;
    logic             idx_last;

    // Handshake: a word transfers on a rising edge where i_valid && i_ready; a sample
    // is consumed where o_valid && o_ready. i_ready is held low while reset is asserted.
    assign i_ready  = reset && (!o_valid || o_ready);
    assign accept   = i_valid && i_ready;
    assign idx_last = (idx == LAST_IDX);

    always_comb begin
        acc_next = acc + i_value;
        if (idx == '0) begin
            acc_next = i_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            o_valid <= 1'b0;
            o_value <= '0;
            idx     <= '0;
            acc     <= '0;
        end else if (accept) begin
            acc     <= acc_next;
            o_value <= acc_next;
            o_valid <= 1'b1;
            idx     <= idx_last ? '0 : idx + IDX_W'(1);
        end else if (o_valid && o_ready) begin
            o_valid <= 1'b0;
        end
    end

`ifdef SECTION_DIFF_RESTORE_LAST_EN
    // Flags the sample restored from the final word of a section.
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_last <= 1'b0;
        end else if (accept) begin
            o_last <= idx_last;
        end
    end
`endif

endmodule
